// File: rtl/video_pos_capture.sv
// video_pos_capture: recovers pixel position from raw HSYNC/VSYNC in the capture clock domain
// and produces the write side of the line buffer plus line/frame length measurements.
module video_pos_capture #(
  parameter int H_TIMEOUT = 4095
) (
  input  logic        PCLK_CAP_i,
  input  logic        reset_n,
  input  logic [7:0]  R_i,
  input  logic [7:0]  G_i,
  input  logic [7:0]  B_i,
  input  logic        HSYNC_i,
  input  logic        VSYNC_i,
  input  logic [31:0] h_in_config,
  input  logic [31:0] v_in_config,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        DE_o,
  output logic [10:0] xpos_o,
  output logic [10:0] ypos_o,
  output logic        FID_o,
  output logic        frame_change_o,
  output logic [11:0] h_total_o,
  output logic [10:0] v_total_o,
  output logic        sync_lost_o
);
  logic [10:0] h_active, v_active, v_cnt, v_tot, v_end;
  logic [8:0]  h_start, v_start;
  logic        h_pol, v_pol;
  logic [23:0] rgb_s1, rgb_s2;
  logic        hs_r, hs_p, vs_r, vs_p, hs_lead, vs_lead, frame_now;
  logic [11:0] h_cnt, h_tot, h_end;
  logic        lost, pend, half_r, half, started, fid, de;
  logic        unused_cfg;

  assign unused_cfg = ^{h_in_config[31:21], v_in_config[31:21]};

  always_comb begin
    {h_pol, h_start, h_active} = h_in_config[20:0];
    {v_pol, v_start, v_active} = v_in_config[20:0];
    hs_lead = hs_r & ~hs_p;
    vs_lead = vs_r & ~vs_p;
    frame_now = hs_lead & (pend | vs_lead);
    half = h_cnt >= {1'b0, h_tot[11:1]};
    h_end = {3'b0, h_start} + {1'b0, h_active};
    v_end = {2'b0, v_start} + v_active;
    de = (h_cnt >= {3'b0, h_start}) & (h_cnt < h_end) &
         (v_cnt >= {2'b0, v_start}) & (v_cnt < v_end) & ~lost;
  end

  // stage 1: input registers, stage 2: counters, stage 3: output registers
  always_ff @(posedge PCLK_CAP_i) begin
    if (!reset_n) begin
      {rgb_s1, rgb_s2, hs_r, hs_p, vs_r, vs_p} <= '0;
      {h_cnt, h_tot, v_cnt, v_tot} <= '0;
      {pend, half_r, started, fid} <= '0;
      lost <= 1'b1;
      {R_o, G_o, B_o, DE_o, xpos_o, ypos_o} <= '0;
      {FID_o, frame_change_o, h_total_o, v_total_o} <= '0;
      sync_lost_o <= 1'b1;
    end else begin
      rgb_s1 <= {R_i, G_i, B_i};
      hs_r <= HSYNC_i ~^ h_pol;
      vs_r <= VSYNC_i ~^ v_pol;
      hs_p <= hs_r;
      vs_p <= vs_r;
      rgb_s2 <= rgb_s1;
      h_cnt <= hs_lead ? '0 : h_cnt + {11'b0, ~&h_cnt};
      lost <= hs_lead ? 1'b0 : (lost | (h_cnt == 12'(H_TIMEOUT)));
      h_tot <= (hs_lead & ~lost) ? h_cnt + 12'd1 : h_tot;
      v_cnt <= frame_now ? '0 : hs_lead ? v_cnt + {10'b0, ~&v_cnt} : v_cnt;
      v_tot <= frame_now ? v_cnt + 11'd1 : v_tot;
      // a VSYNC edge coinciding with HSYNC always starts an even field
      fid <= frame_now ? (~vs_lead & half_r) : fid;
      started <= started | frame_now;
      pend <= hs_lead ? 1'b0 : (pend | vs_lead);
      half_r <= (vs_lead & ~hs_lead) ? half : half_r;
      {R_o, G_o, B_o} <= rgb_s2;
      DE_o <= de;
      xpos_o <= de ? 11'(h_cnt - {3'b0, h_start}) : xpos_o;
      ypos_o <= de ? v_cnt - {2'b0, v_start} : ypos_o;
      FID_o <= fid;
      frame_change_o <= started & (v_cnt == '0);
      h_total_o <= h_tot;
      v_total_o <= v_tot;
      sync_lost_o <= lost;
    end
  end
endmodule
